// File: rtl/alu_mdu_control_pkg.sv
// Shared types and encodings for EX-stage ALU select and RV32M sequencing.
package alu_mdu_control_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_XXX  = 4'd15
    } alu_sel_e;

    // Encoded identically to funct3 so the raw field can be cast directly.
    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    typedef logic [1:0] mdu_state_e;
    localparam mdu_state_e ST_IDLE = 2'd0;
    localparam mdu_state_e ST_BUSY = 2'd1;
    localparam mdu_state_e ST_DONE = 2'd2;

    localparam logic [1:0] ALU_OP_MEM    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_R      = 2'b10;
    localparam logic [1:0] ALU_OP_I      = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    function automatic alu_sel_e f3_to_sel(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_mdu_control_mdu_iter.sv
// Radix-2 datapath: shift-add multiplier and restoring divider on operand magnitudes.
module alu_mdu_control_mdu_iter
    import alu_mdu_control_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  mdu_op_e         op,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    input  logic            step,
    output logic [XLEN-1:0] result
);

    mdu_op_e         op_q;
    logic            neg_q_q, neg_r_q;
    logic [XLEN-1:0] acc_q, sh_q, opd_q;

    logic            a_neg, b_neg, is_div;
    logic [XLEN-1:0] a_mag, b_mag, acc_nxt, sh_nxt, q_fix, r_fix;
    logic [XLEN:0]   add_sum, sub_shift, sub_diff;
    logic [2*XLEN-1:0] prod, prod_fix;

    // Operand sign stripping at start; MUL stays unsigned since its low half is sign-agnostic.
    always_comb begin
        a_neg = (op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM}) && opa[XLEN-1];
        b_neg = (op inside {MDU_MULH, MDU_DIV, MDU_REM}) && opb[XLEN-1];
        a_mag = a_neg ? -opa : opa;
        b_mag = b_neg ? -opb : opb;
    end

    // One iteration; result is taken from the post-step values so the last step lands in the same cycle.
    always_comb begin
        is_div    = op_q inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
        add_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opd_q} : '0);
        sub_shift = {acc_q, sh_q[XLEN-1]};
        sub_diff  = sub_shift - {1'b0, opd_q};
        if (is_div) begin
            if (!sub_diff[XLEN]) begin
                acc_nxt = sub_diff[XLEN-1:0];
                sh_nxt  = {sh_q[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = sub_shift[XLEN-1:0];
                sh_nxt  = {sh_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nxt = add_sum[XLEN:1];
            sh_nxt  = {add_sum[0], sh_q[XLEN-1:1]};
        end
        prod     = {acc_nxt, sh_nxt};
        prod_fix = neg_q_q ? -prod : prod;
        q_fix    = neg_q_q ? -sh_nxt : sh_nxt;
        r_fix    = neg_r_q ? -acc_nxt : acc_nxt;
        case (op_q)
            MDU_MUL:                          result = prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:                result = q_fix;
            default:                          result = r_fix;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= MDU_MUL;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            acc_q   <= '0;
            sh_q    <= '0;
            opd_q   <= '0;
        end else if (start) begin
            op_q    <= op;
            neg_q_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
            acc_q   <= '0;
            sh_q    <= op[2] ? a_mag : b_mag;
            opd_q   <= op[2] ? b_mag : a_mag;
        end else if (step) begin
            acc_q <= acc_nxt;
            sh_q  <= sh_nxt;
        end
    end

endmodule

// File: rtl/alu_mdu_control.sv
// EX-stage operation control: RV32I ALU select decode plus RV32M multicycle sequencing.
module alu_mdu_control
    import alu_mdu_control_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter bit          M_EXT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output alu_sel_e        alu_sel,
    output logic            use_mdu,
    output logic            illegal_o,
    output logic            stall_o,
    output logic            mdu_done,
    output logic [XLEN-1:0] mdu_result
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    logic is_m_enc, bad_enc, is_m;

    // Combinational decode, independent of valid_i.
    always_comb begin
        alu_sel  = ALU_XXX;
        is_m_enc = 1'b0;
        bad_enc  = 1'b0;
        case (alu_op)
            ALU_OP_MEM:    alu_sel = ALU_ADD;
            ALU_OP_BRANCH: alu_sel = ALU_SUB;
            ALU_OP_R: begin
                if (funct7 == F7_BASE) begin
                    alu_sel = f3_to_sel(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    alu_sel = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    alu_sel = ALU_SRA;
                end else if (funct7 == F7_MULDIV) begin
                    is_m_enc = 1'b1;
                end else begin
                    bad_enc = 1'b1;
                end
            end
            default: begin
                if (funct3 == 3'b001) begin
                    if (funct7 == F7_BASE) alu_sel = ALU_SLL;
                    else                   bad_enc = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_BASE)     alu_sel = ALU_SRL;
                    else if (funct7 == F7_ALT) alu_sel = ALU_SRA;
                    else                       bad_enc = 1'b1;
                end else begin
                    alu_sel = f3_to_sel(funct3);
                end
            end
        endcase
    end

    assign is_m      = is_m_enc & M_EXT;
    assign use_mdu   = is_m;
    assign illegal_o = valid_i & (bad_enc | (is_m_enc & ~M_EXT));

    if (M_EXT) begin : g_mdu
        mdu_state_e      state_q, state_d;
        logic [CNT_W-1:0] count_q, count_d;
        logic [XLEN-1:0] result_q, result_d, fast_res, iter_res;
        logic            accept, fast, div_zero, ovf, start, step;

        // Divide-by-zero and MIN/-1 finish in the accept cycle without iterating.
        always_comb begin
            div_zero = (rs2_val == '0);
            ovf      = !funct3[0] && (rs1_val == XMIN) && (rs2_val == '1);
            fast     = funct3[2] && (div_zero || ovf);
            if (div_zero) fast_res = funct3[1] ? rs1_val : '1;
            else          fast_res = funct3[1] ? '0 : XMIN;
        end

        assign accept = valid_i & is_m & ~flush_i & (state_q == ST_IDLE);

        always_comb begin
            state_d  = state_q;
            count_d  = count_q;
            result_d = result_q;
            start    = 1'b0;
            step     = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        start = 1'b1;
                        if (fast) begin
                            state_d  = ST_DONE;
                            result_d = fast_res;
                        end else begin
                            state_d = ST_BUSY;
                            count_d = CNT_W'(XLEN - 1);
                        end
                    end
                end
                ST_BUSY: begin
                    step = 1'b1;
                    if (count_q == '0) begin
                        state_d  = ST_DONE;
                        result_d = iter_res;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (flush_i) begin
                state_d  = ST_IDLE;
                result_d = result_q;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q  <= ST_IDLE;
                count_q  <= '0;
                result_q <= '0;
            end else begin
                state_q  <= state_d;
                count_q  <= count_d;
                result_q <= result_d;
            end
        end

        alu_mdu_control_mdu_iter #(.XLEN(XLEN)) u_mdu_iter (
            .clk    (clk),
            .rst    (rst),
            .start  (start),
            .op     (mdu_op_e'(funct3)),
            .opa    (rs1_val),
            .opb    (rs2_val),
            .step   (step),
            .result (iter_res)
        );

        assign stall_o    = valid_i & is_m & (state_q != ST_DONE) & ~flush_i & ~rst;
        assign mdu_done   = (state_q == ST_DONE);
        assign mdu_result = result_q;
    end else begin : g_no_mdu
        logic unused_mdu;
        assign unused_mdu = ^{clk, rst, flush_i, rs1_val, rs2_val};
        assign stall_o    = 1'b0;
        assign mdu_done   = 1'b0;
        assign mdu_result = '0;
    end

endmodule

// File: tb/tb_alu_mdu_control.sv
// Directed bench for alu_mdu_control: decode table, M-op latency/results, fast paths, flush, reset.
module tb_alu_mdu_control;
    import alu_mdu_control_pkg::*;

    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst, valid_i, flush_i;
    logic [1:0]  alu_op;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val;

    alu_sel_e    alu_sel, alu_sel_n;
    logic        use_mdu, illegal_o, stall_o, mdu_done;
    logic        use_mdu_n, illegal_n, stall_n, done_n;
    logic [31:0] mdu_result, result_n;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_mdu_control #(.XLEN(XLEN), .M_EXT(1'b1)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i),
        .alu_op(alu_op), .funct7(funct7), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .alu_sel(alu_sel), .use_mdu(use_mdu), .illegal_o(illegal_o),
        .stall_o(stall_o), .mdu_done(mdu_done), .mdu_result(mdu_result)
    );

    alu_mdu_control #(.XLEN(XLEN), .M_EXT(1'b0)) dut_nom (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i),
        .alu_op(alu_op), .funct7(funct7), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .alu_sel(alu_sel_n), .use_mdu(use_mdu_n), .illegal_o(illegal_n),
        .stall_o(stall_n), .mdu_done(done_n), .mdu_result(result_n)
    );

    // {alu_op, funct7, funct3, expected alu_sel}; ALU_XXX entries are expected illegal.
    localparam logic [15:0] DEC_VEC [17] = '{
        {2'b10, 7'b0100000, 3'b101, ALU_SRA},
        {2'b11, 7'b0100000, 3'b000, ALU_ADD},
        {2'b00, 7'b0000000, 3'b111, ALU_ADD},
        {2'b01, 7'b1111111, 3'b010, ALU_SUB},
        {2'b10, 7'b0000000, 3'b010, ALU_SLT},
        {2'b10, 7'b0000000, 3'b011, ALU_SLTU},
        {2'b10, 7'b0100000, 3'b000, ALU_SUB},
        {2'b10, 7'b0100000, 3'b001, ALU_XXX},
        {2'b11, 7'b0000000, 3'b101, ALU_SRL},
        {2'b11, 7'b0000001, 3'b001, ALU_XXX},
        {2'b11, 7'b1111111, 3'b111, ALU_AND},
        {2'b10, 7'b1111111, 3'b000, ALU_XXX},
        {2'b10, 7'b0000000, 3'b100, ALU_XOR},
        {2'b10, 7'b0000000, 3'b110, ALU_OR},
        {2'b10, 7'b0000000, 3'b001, ALU_SLL},
        {2'b11, 7'b0000001, 3'b101, ALU_XXX},
        {2'b11, 7'b0100000, 3'b101, ALU_SRA}
    };

    // Present an M op on the cycle after the next edge and wait for mdu_done (bounded).
    task automatic issue_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             output int lat, output logic [31:0] res, output logic stall_ok);
        @(posedge clk); #1;
        valid_i = 1'b1; flush_i = 1'b0;
        alu_op = 2'b10; funct7 = 7'b0000001; funct3 = f3;
        rs1_val = a; rs2_val = b;
        #1;
        lat = 0;
        stall_ok = 1'b1;
        while (!mdu_done && lat < 100) begin
            if (stall_o !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #2;
            lat++;
        end
        res = mdu_result;
        if (stall_o !== 1'b0) stall_ok = 1'b0;
    endtask

    task automatic retire;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
        alu_op = 2'b00; funct7 = '0; funct3 = '0; rs1_val = '0; rs2_val = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (mdu_result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", mdu_result); else passed++;
        checks++; if (mdu_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", mdu_done); else passed++;
        checks++; if (stall_o !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall_o); else passed++;
        checks++; if (illegal_o !== 1'b0) $display("FAIL reset_illegal: got %b expected 0", illegal_o); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_decode;
        logic [15:0] v;
        logic exp_ill;
        valid_i = 1'b1; flush_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            v = DEC_VEC[i];
            alu_op = v[15:14]; funct7 = v[13:7]; funct3 = v[6:4];
            exp_ill = (v[3:0] == 4'(ALU_XXX));
            #2;
            checks++; if (alu_sel !== alu_sel_e'(v[3:0])) $display("FAIL decode_sel[%0d]: got %0d expected %0d", i, alu_sel, v[3:0]); else passed++;
            checks++; if (illegal_o !== exp_ill) $display("FAIL decode_illegal[%0d]: got %b expected %b", i, illegal_o, exp_ill); else passed++;
            checks++; if (stall_o !== 1'b0) $display("FAIL decode_stall[%0d]: got %b expected 0", i, stall_o); else passed++;
        end
        valid_i = 1'b0;
    endtask

    task automatic test_mul;
        int lat; logic [31:0] res; logic sok;
        issue_mop(3'b000, 32'd7, 32'hFFFF_FFFD, lat, res, sok);
        checks++; if (lat !== 33) $display("FAIL mul_latency: got %0d expected 33", lat); else passed++;
        checks++; if (res !== 32'hFFFF_FFEB) $display("FAIL mul_result: got %h expected ffffffeb", res); else passed++;
        checks++; if (sok !== 1'b1) $display("FAIL mul_stall: stall window got %b expected 1", sok); else passed++;
        retire();
        #1;
        checks++; if (mdu_done !== 1'b0) $display("FAIL mul_done_pulse: got %b expected 0", mdu_done); else passed++;
    endtask

    task automatic test_mulh;
        int lat; logic [31:0] res; logic sok;
        issue_mop(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, sok);
        checks++; if (res !== 32'hFFFF_FFFE || lat !== 33) $display("FAIL mulhu: got %h/%0d expected fffffffe/33", res, lat); else passed++;
        retire();
        issue_mop(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, sok);
        checks++; if (res !== 32'h0000_0000) $display("FAIL mulh_neg: got %h expected 00000000", res); else passed++;
        retire();
        issue_mop(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, sok);
        checks++; if (res !== 32'hFFFF_FFFF) $display("FAIL mulhsu: got %h expected ffffffff", res); else passed++;
        retire();
        issue_mop(3'b001, 32'h8000_0000, 32'h8000_0000, lat, res, sok);
        checks++; if (res !== 32'h4000_0000) $display("FAIL mulh_min: got %h expected 40000000", res); else passed++;
        retire();
    endtask

    task automatic test_div;
        int lat; logic [31:0] res; logic sok;
        issue_mop(3'b100, 32'hFFFF_FFF9, 32'd2, lat, res, sok);
        checks++; if (res !== 32'hFFFF_FFFD || lat !== 33) $display("FAIL div_neg: got %h/%0d expected fffffffd/33", res, lat); else passed++;
        retire();
        issue_mop(3'b110, 32'hFFFF_FFF9, 32'd2, lat, res, sok);
        checks++; if (res !== 32'hFFFF_FFFF) $display("FAIL rem_neg: got %h expected ffffffff", res); else passed++;
        retire();
        issue_mop(3'b110, 32'd7, 32'hFFFF_FFFE, lat, res, sok);
        checks++; if (res !== 32'h0000_0001) $display("FAIL rem_negdiv: got %h expected 00000001", res); else passed++;
        retire();
        issue_mop(3'b111, 32'd100, 32'd7, lat, res, sok);
        checks++; if (res !== 32'h0000_0002) $display("FAIL remu: got %h expected 00000002", res); else passed++;
        retire();
        issue_mop(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, sok);
        checks++; if (res !== 32'h0000_0000 || lat !== 33) $display("FAIL divu_nofast: got %h/%0d expected 00000000/33", res, lat); else passed++;
        retire();
    endtask

    task automatic test_fast_paths;
        int lat; logic [31:0] res; logic sok;
        issue_mop(3'b101, 32'd5, 32'd0, lat, res, sok);
        checks++; if (lat !== 1) $display("FAIL divu0_latency: got %0d expected 1", lat); else passed++;
        checks++; if (res !== 32'hFFFF_FFFF) $display("FAIL divu0_result: got %h expected ffffffff", res); else passed++;
        retire();
        issue_mop(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, sok);
        checks++; if (res !== 32'h0000_0000 || lat !== 1) $display("FAIL rem_ovf: got %h/%0d expected 00000000/1", res, lat); else passed++;
        retire();
        issue_mop(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, sok);
        checks++; if (res !== 32'h8000_0000 || lat !== 1) $display("FAIL div_ovf: got %h/%0d expected 80000000/1", res, lat); else passed++;
        retire();
        issue_mop(3'b100, 32'hFFFF_FFF9, 32'd0, lat, res, sok);
        checks++; if (res !== 32'hFFFF_FFFF || lat !== 1) $display("FAIL div0: got %h/%0d expected ffffffff/1", res, lat); else passed++;
        retire();
        issue_mop(3'b110, 32'hFFFF_FFF9, 32'd0, lat, res, sok);
        checks++; if (res !== 32'hFFFF_FFF9 || sok !== 1'b1) $display("FAIL rem0: got %h stall %b expected fffffff9 stall 1", res, sok); else passed++;
        retire();
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] res; logic sok;
        issue_mop(3'b000, 32'd6, 32'd7, lat, res, sok);
        checks++; if (res !== 32'd42 || lat !== 33) $display("FAIL b2b_mul: got %h/%0d expected 0000002a/33", res, lat); else passed++;
        issue_mop(3'b101, 32'd100, 32'd7, lat, res, sok);
        checks++; if (lat !== 33) $display("FAIL b2b_divu_latency: got %0d expected 33", lat); else passed++;
        checks++; if (res !== 32'd14) $display("FAIL b2b_divu_result: got %h expected 0000000e", res); else passed++;
        retire();
    endtask

    task automatic test_flush;
        int lat; int early; logic [31:0] res; logic sok;
        issue_mop(3'b111, 32'd5, 32'd0, lat, res, sok);
        checks++; if (res !== 32'd5) $display("FAIL flush_pre: got %h expected 00000005", res); else passed++;
        retire();
        @(posedge clk); #1;
        valid_i = 1'b1; alu_op = 2'b10; funct7 = 7'b0000001; funct3 = 3'b100;
        rs1_val = 32'd100; rs2_val = 32'hFFFF_FFF9;
        early = 0;
        repeat (10) begin
            @(posedge clk); #2;
            if (mdu_done) early++;
        end
        flush_i = 1'b1; #1;
        checks++; if (stall_o !== 1'b0) $display("FAIL flush_stall: got %b expected 0", stall_o); else passed++;
        @(posedge clk); #1;
        flush_i = 1'b0; #1;
        checks++; if (mdu_result !== 32'd5) $display("FAIL flush_result_held: got %h expected 00000005", mdu_result); else passed++;
        lat = 0;
        while (!mdu_done && lat < 100) begin
            @(posedge clk); #2;
            lat++;
        end
        checks++; if (early !== 0) $display("FAIL flush_no_done: got %0d pulses expected 0", early); else passed++;
        checks++; if (lat !== 33) $display("FAIL flush_restart_latency: got %0d expected 33", lat); else passed++;
        checks++; if (mdu_result !== 32'hFFFF_FFF2) $display("FAIL flush_restart_result: got %h expected fffffff2", mdu_result); else passed++;
        retire();
    endtask

    task automatic test_reset_mid;
        int seen;
        @(posedge clk); #1;
        valid_i = 1'b1; alu_op = 2'b10; funct7 = 7'b0000001; funct3 = 3'b000;
        rs1_val = 32'd7; rs2_val = 32'd3;
        repeat (5) @(posedge clk);
        #1; rst = 1'b1; #1;
        checks++; if (stall_o !== 1'b0) $display("FAIL rst_mid_stall: got %b expected 0", stall_o); else passed++;
        checks++; if (mdu_done !== 1'b0) $display("FAIL rst_mid_done: got %b expected 0", mdu_done); else passed++;
        checks++; if (mdu_result !== 32'h0) $display("FAIL rst_mid_result: got %h expected 00000000", mdu_result); else passed++;
        valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #2;
            if (mdu_done) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL rst_mid_abort: got %0d done pulses expected 0", seen); else passed++;
    endtask

    task automatic test_no_mext;
        #1;
        valid_i = 1'b1; flush_i = 1'b1;
        alu_op = 2'b10; funct7 = 7'b0000001; funct3 = 3'b000;
        #1;
        checks++; if (illegal_n !== 1'b1) $display("FAIL nomext_illegal: got %b expected 1", illegal_n); else passed++;
        checks++; if (use_mdu_n !== 1'b0) $display("FAIL nomext_use_mdu: got %b expected 0", use_mdu_n); else passed++;
        checks++; if (stall_n !== 1'b0 || done_n !== 1'b0) $display("FAIL nomext_stall_done: got %b%b expected 00", stall_n, done_n); else passed++;
        checks++; if (result_n !== 32'h0) $display("FAIL nomext_result: got %h expected 00000000", result_n); else passed++;
        checks++; if (alu_sel_n !== ALU_XXX) $display("FAIL nomext_sel: got %0d expected %0d", alu_sel_n, ALU_XXX); else passed++;
        checks++; if (illegal_o !== 1'b0 || use_mdu !== 1'b1) $display("FAIL mext_decode: got ill %b use %b expected 0 1", illegal_o, use_mdu); else passed++;
        valid_i = 1'b0;
        #1; flush_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mul();
        test_mulh();
        test_div();
        test_fast_paths();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_no_mext();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
